// File: rtl/video_timing_decoder.sv
// -----------------------------------------------------------------------------
// video_timing_decoder
//
// Receive-side counterpart of the H/V timing generator. Samples the
// ce_pix-qualified sync/blank/RGB stream on clk_sys, rebuilds the active
// pixel coordinates and a data-enable, measures line and frame geometry, and
// reports lock once the measured geometry repeats for LOCK_FRAMES frames.
//
// Ports:
//   clk_sys   in   system clock
//   reset_n   in   asynchronous active-low reset
//   ce_pix    in   pixel clock enable; inputs are sampled only when 1
//   hb, vb    in   horizontal / vertical blank, active high
//   hs, vs    in   horizontal / vertical sync, active low
//   rgb_in    in   pixel {R,G,B}
//   de        out  registered ~(hb|vb)
//   rgb_out   out  rgb_in aligned with de/x/y, zero while de=0
//   x, y      out  active pixel / active line index
//   sol, sof  out  one-clk pulses: start of active line / first pixel of frame
//   h_total   out  ce_pix periods between hs falling edges
//   h_active  out  ce_pix periods with hb=0 in the last line
//   v_total   out  lines between vs falling edges
//   v_active  out  active lines in the last frame
//   locked    out  geometry stable
// -----------------------------------------------------------------------------
module video_timing_decoder #(
    parameter int HCNT_W      = 10,
    parameter int VCNT_W      = 9,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic              hb,
    input  logic              vb,
    input  logic              hs,
    input  logic              vs,
    input  logic [23:0]       rgb_in,
    output logic              de,
    output logic [23:0]       rgb_out,
    output logic [HCNT_W-1:0] x,
    output logic [VCNT_W-1:0] y,
    output logic              sol,
    output logic              sof,
    output logic [HCNT_W-1:0] h_total,
    output logic [HCNT_W-1:0] h_active,
    output logic [VCNT_W-1:0] v_total,
    output logic [VCNT_W-1:0] v_active,
    output logic              locked
);

    typedef enum logic [1:0] {
        S_UNLOCKED,
        S_LOCKING,
        S_LOCKED
    } lock_state_t;

    localparam int TUPLE_W = 2 * HCNT_W + 2 * VCNT_W;
    localparam int WD_W    = HCNT_W + 1;

    function automatic logic [HCNT_W-1:0] h_inc(input logic [HCNT_W-1:0] val);
        return (&val) ? val : val + HCNT_W'(1);
    endfunction

    function automatic logic [VCNT_W-1:0] v_inc(input logic [VCNT_W-1:0] val);
        return (&val) ? val : val + VCNT_W'(1);
    endfunction

    // Previous-sample registers for edge detection
    logic hb_q, vb_q, hs_q, vs_q;

    // Counters
    logic [HCNT_W-1:0] hcnt, hs_cnt;
    logic [VCNT_W-1:0] line_cnt, act_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              vb_pend;  // vb has fallen, first active line not yet seen

    // Lock tracking
    lock_state_t        state, state_nx;
    logic [TUPLE_W-1:0] ref_tuple, ref_nx;
    logic [2:0]         lock_cnt, lock_cnt_nx;

    // Combinational next values
    logic hb_fall, hb_rise, vb_fall, vb_rise, hs_fall, vs_fall;
    logic sol_ev, sof_ev, wd_trip, de_nx, vb_pend_nx;
    logic [HCNT_W-1:0]  hcnt_nx, hs_cnt_nx, x_nx, h_total_nx, h_active_nx;
    logic [VCNT_W-1:0]  vcnt_nx, line_cnt_nx, act_cnt_nx, v_total_nx, v_active_nx;
    logic [WD_W-1:0]    wd_nx;
    logic [23:0]        rgb_nx;
    logic [TUPLE_W-1:0] tuple_nx;

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        hb_fall = hb_q & ~hb;
        hb_rise = ~hb_q & hb;
        vb_fall = vb_q & ~vb;
        vb_rise = ~vb_q & vb;
        hs_fall = hs_q & ~hs;
        vs_fall = vs_q & ~vs;

        // Horizontal position
        hcnt_nx = hb_fall ? '0 : h_inc(hcnt);
        de_nx   = ~(hb | vb);
        x_nx    = de_nx ? hcnt_nx : x;
        rgb_nx  = de_nx ? rgb_in : '0;

        // Line starts; the first one after vb falls opens the frame
        sol_ev     = hb_fall & ~vb;
        sof_ev     = sol_ev & (vb_pend | vb_fall);
        vb_pend_nx = (vb_pend | vb_fall) & ~sof_ev;

        vcnt_nx = y;
        if (sof_ev) begin
            vcnt_nx = '0;
        end else if (sol_ev) begin
            vcnt_nx = v_inc(y);
        end

        // Active-line count restarts with each vertical active period
        act_cnt_nx = vb_fall ? '0 : act_cnt;
        if (sol_ev) begin
            act_cnt_nx = v_inc(act_cnt_nx);
        end

        // Sync-based counting; the line in which vs falls is line 1
        hs_cnt_nx = hs_fall ? '0 : h_inc(hs_cnt);
        line_cnt_nx = line_cnt;
        if (vs_fall) begin
            line_cnt_nx = VCNT_W'(1);
        end else if (hs_fall) begin
            line_cnt_nx = v_inc(line_cnt);
        end

        // Watchdog saturates at 2^HCNT_W samples without an hs falling edge and
        // keeps the measurements cleared until lines resume.
        wd_nx   = hs_fall ? '0 : (wd_cnt[HCNT_W] ? wd_cnt : wd_cnt + WD_W'(1));
        wd_trip = wd_nx[HCNT_W];

        // Measurements (old line_cnt is used, so v_total latches before restart)
        h_total_nx  = hs_fall ? h_inc(hs_cnt) : h_total;
        h_active_nx = hb_rise ? h_inc(hcnt) : h_active;
        v_total_nx  = vs_fall ? line_cnt : v_total;
        v_active_nx = vb_rise ? act_cnt : v_active;
        if (wd_trip) begin
            h_total_nx  = '0;
            h_active_nx = '0;
            v_total_nx  = '0;
            v_active_nx = '0;
        end
        tuple_nx = {h_total_nx, h_active_nx, v_total_nx, v_active_nx};
    end

    // Lock state machine: next-state logic, evaluated on vs falling edges
    always_comb begin
        state_nx    = state;
        ref_nx      = ref_tuple;
        lock_cnt_nx = lock_cnt;
        if (ce_pix) begin
            if (wd_trip) begin
                state_nx    = S_UNLOCKED;
                lock_cnt_nx = '0;
            end else if (vs_fall) begin
                case (state)
                    S_UNLOCKED: begin
                        ref_nx      = tuple_nx;
                        lock_cnt_nx = 3'd1;
                        state_nx    = S_LOCKING;
                    end
                    S_LOCKING: begin
                        if (tuple_nx == ref_tuple) begin
                            lock_cnt_nx = lock_cnt + 3'd1;
                            if (lock_cnt_nx >= 3'(LOCK_FRAMES)) begin
                                state_nx = S_LOCKED;
                            end
                        end else begin
                            ref_nx      = tuple_nx;
                            lock_cnt_nx = 3'd1;
                        end
                    end
                    S_LOCKED: begin
                        if (tuple_nx != ref_tuple) begin
                            state_nx    = S_UNLOCKED;
                            lock_cnt_nx = '0;
                        end
                    end
                    default: begin
                        state_nx    = S_UNLOCKED;
                        lock_cnt_nx = '0;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_UNLOCKED;
            ref_tuple <= '0;
            lock_cnt  <= '0;
        end else begin
            state     <= state_nx;
            ref_tuple <= ref_nx;
            lock_cnt  <= lock_cnt_nx;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hb_q     <= 1'b1;
            vb_q     <= 1'b1;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            vb_pend  <= 1'b0;
            hcnt     <= '0;
            hs_cnt   <= '0;
            line_cnt <= '0;
            act_cnt  <= '0;
            wd_cnt   <= '0;
            de       <= 1'b0;
            rgb_out  <= '0;
            x        <= '0;
            y        <= '0;
            sol      <= 1'b0;
            sof      <= 1'b0;
            h_total  <= '0;
            h_active <= '0;
            v_total  <= '0;
            v_active <= '0;
        end else begin
            // Pulses are rebuilt every clk_sys cycle so they last exactly one
            sol <= ce_pix & sol_ev;
            sof <= ce_pix & sof_ev;
            if (ce_pix) begin
                hb_q     <= hb;
                vb_q     <= vb;
                hs_q     <= hs;
                vs_q     <= vs;
                vb_pend  <= vb_pend_nx;
                hcnt     <= hcnt_nx;
                hs_cnt   <= hs_cnt_nx;
                line_cnt <= line_cnt_nx;
                act_cnt  <= act_cnt_nx;
                wd_cnt   <= wd_nx;
                de       <= de_nx;
                rgb_out  <= rgb_nx;
                x        <= x_nx;
                y        <= vcnt_nx;
                h_total  <= h_total_nx;
                h_active <= h_active_nx;
                v_total  <= v_total_nx;
                v_active <= v_active_nx;
            end
        end
    end

    assign locked = (state == S_LOCKED);

endmodule

// File: tb/tb_video_timing_decoder.sv
// -----------------------------------------------------------------------------
// tb_video_timing_decoder
//
// Directed bench for video_timing_decoder. A small frame generator drives a
// compact raster (geometry held in g_* variables) and gathers per-frame
// statistics from the loop indices; each test task then compares those
// statistics and the measurement outputs against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_timing_decoder;

    localparam int HCNT_W = 10;
    localparam int VCNT_W = 9;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              ce_pix  = 1'b0;
    logic              hb = 1'b1, vb = 1'b1, hs = 1'b1, vs = 1'b1;
    logic [23:0]       rgb_in = '0;
    logic              de, sol, sof, locked;
    logic [23:0]       rgb_out;
    logic [HCNT_W-1:0] x, h_total, h_active;
    logic [VCNT_W-1:0] y, v_total, v_active;
    logic [84:0]       all_out;

    int checks = 0;
    int errors = 0;

    // Raster geometry for the generator
    int g_htot, g_hact, g_hs_start, g_hs_len;
    int g_vtot, g_vact, g_vs_start, g_vs_len;
    int g_gap, g_mode;

    // Values captured one cycle after each ce_pix sample
    logic              s_de, s_sol, s_sof, s_locked;
    logic [HCNT_W-1:0] s_x;
    logic [VCNT_W-1:0] s_y;
    logic [23:0]       s_rgb;

    // Per-frame statistics
    int   de_err, pos_err, rgb_err, pulse_err, hold_err;
    int   sol_cnt, sof_cnt, max_x, max_y, a5_hits, a5_total;
    logic lk_vs, first_sof, prev_vs_tb = 1'b1;
    int   first_x, first_y, frame_errs;

    always #5 clk_sys = ~clk_sys;

    assign all_out = {de, rgb_out, x, y, sol, sof, h_total, h_active,
                      v_total, v_active, locked};

    video_timing_decoder #(
        .HCNT_W      (HCNT_W),
        .VCNT_W      (VCNT_W),
        .LOCK_FRAMES (2)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce_pix   (ce_pix),
        .hb       (hb),
        .vb       (vb),
        .hs       (hs),
        .vs       (vs),
        .rgb_in   (rgb_in),
        .de       (de),
        .rgb_out  (rgb_out),
        .x        (x),
        .y        (y),
        .sol      (sol),
        .sof      (sof),
        .h_total  (h_total),
        .h_active (h_active),
        .v_total  (v_total),
        .v_active (v_active),
        .locked   (locked)
    );

    task automatic set_geom(input int htot, input int hact, input int hs_start,
                            input int hs_len, input int vtot, input int vact,
                            input int vs_start, input int vs_len, input int gap,
                            input int mode);
        g_htot = htot; g_hact = hact; g_hs_start = hs_start; g_hs_len = hs_len;
        g_vtot = vtot; g_vact = vact; g_vs_start = vs_start; g_vs_len = vs_len;
        g_gap = gap; g_mode = mode;
    endtask

    // One ce_pix sample followed by g_gap idle clk_sys cycles
    task automatic pix(input logic hb_i, input logic vb_i, input logic hs_i,
                       input logic vs_i, input logic [23:0] rgb_i);
        hb = hb_i; vb = vb_i; hs = hs_i; vs = vs_i; rgb_in = rgb_i;
        ce_pix = 1'b1;
        @(posedge clk_sys); #1;
        ce_pix = 1'b0;
        s_de = de; s_sol = sol; s_sof = sof; s_locked = locked;
        s_x = x; s_y = y; s_rgb = rgb_out;
        for (int i = 0; i < g_gap; i++) begin
            @(posedge clk_sys); #1;
            if (sol !== 1'b0 || sof !== 1'b0) pulse_err++;
            if (de !== s_de || x !== s_x || y !== s_y || rgb_out !== s_rgb ||
                locked !== s_locked) hold_err++;
        end
    endtask

    task automatic run_frame(input int nlines);
        logic e_hb, e_vb, e_hs, e_vs, e_de, e_sol, in_vs, pre_end;
        logic [23:0] rgb_i;
        de_err = 0; pos_err = 0; rgb_err = 0; pulse_err = 0; hold_err = 0;
        sol_cnt = 0; sof_cnt = 0; max_x = -1; max_y = -1; a5_hits = 0; a5_total = 0;
        for (int v = 0; v < nlines; v++) begin
            for (int h = 0; h < g_htot; h++) begin
                e_hb    = (h >= g_hact);
                e_vb    = (v >= g_vact);
                e_hs    = !(h >= g_hs_start && h < g_hs_start + g_hs_len);
                in_vs   = (v > g_vs_start) || (v == g_vs_start && h >= g_hs_start);
                pre_end = (v < g_vs_start + g_vs_len) ||
                          (v == g_vs_start + g_vs_len && h < g_hs_start);
                e_vs    = !(in_vs && pre_end);
                if (g_mode == 0) rgb_i = {h[7:0], v[7:0], 8'h3C};
                else             rgb_i = (h == 0 || e_hb) ? 24'hA5A5A5 : 24'h0;
                pix(e_hb, e_vb, e_hs, e_vs, rgb_i);
                e_de  = !(e_hb || e_vb);
                e_sol = (h == 0) && (v < g_vact);
                if (s_de !== e_de) de_err++;
                if (e_de && (s_x !== HCNT_W'(h) || s_y !== VCNT_W'(v))) pos_err++;
                if (s_rgb !== (e_de ? rgb_i : 24'h0)) rgb_err++;
                if (s_sol !== e_sol) pulse_err++;
                if (s_sof !== (h == 0 && v == 0)) pulse_err++;
                if (s_sol === 1'b1) sol_cnt++;
                if (s_sof === 1'b1) sof_cnt++;
                if (s_de === 1'b1 && int'(s_x) > max_x) max_x = int'(s_x);
                if (s_de === 1'b1 && int'(s_y) > max_y) max_y = int'(s_y);
                if (s_de === 1'b1 && s_sol === 1'b1 && s_x === '0 &&
                    s_rgb === 24'hA5A5A5) a5_hits++;
                if (s_rgb === 24'hA5A5A5) a5_total++;
                if (prev_vs_tb && !e_vs) lk_vs = s_locked;
                prev_vs_tb = e_vs;
                if (v == 0 && h == 0) begin
                    first_x = int'(s_x); first_y = int'(s_y); first_sof = s_sof;
                end
            end
        end
        frame_errs = de_err + pos_err + rgb_err + pulse_err + hold_err;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            {hb, vb, hs, vs, ce_pix} = 5'($urandom);
            rgb_in = 24'($urandom);
            @(posedge clk_sys); #1;
        end
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_held: outputs=%h expected 0", all_out);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        ce_pix  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            {hb, vb, hs, vs} = 4'($urandom);
            rgb_in = 24'($urandom);
            @(posedge clk_sys); #1;
        end
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_release_no_ce: outputs=%h expected 0", all_out);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL reset_locked: got %b expected 0", locked);
        end
        hb = 1'b1; vb = 1'b1; hs = 1'b1; vs = 1'b1; rgb_in = '0;
    endtask

    task automatic test_nominal();
        set_geom(28, 16, 22, 3, 12, 8, 9, 2, 9, 0);
        run_frame(g_vtot);
        checks++;
        if (lk_vs !== 1'b0) begin
            errors++; $display("FAIL nominal_lock_edge1: got %b expected 0", lk_vs);
        end
        checks++;
        if (frame_errs !== 0) begin
            errors++; $display("FAIL nominal_frame1_stream: got %0d errors expected 0", frame_errs);
        end
        run_frame(g_vtot);
        checks++;
        if (lk_vs !== 1'b0) begin
            errors++; $display("FAIL nominal_lock_edge2: got %b expected 0", lk_vs);
        end
        run_frame(g_vtot);
        checks++;
        if (lk_vs !== 1'b1) begin
            errors++; $display("FAIL nominal_lock_edge3: got %b expected 1", lk_vs);
        end
        checks++;
        if (h_total !== 10'd28) begin
            errors++; $display("FAIL nominal_h_total: got %0d expected 28", h_total);
        end
        checks++;
        if (h_active !== 10'd16) begin
            errors++; $display("FAIL nominal_h_active: got %0d expected 16", h_active);
        end
        checks++;
        if (v_total !== 9'd12) begin
            errors++; $display("FAIL nominal_v_total: got %0d expected 12", v_total);
        end
        checks++;
        if (v_active !== 9'd8) begin
            errors++; $display("FAIL nominal_v_active: got %0d expected 8", v_active);
        end
        checks++;
        if (max_x !== 15 || max_y !== 7) begin
            errors++; $display("FAIL nominal_xy_range: got x<=%0d y<=%0d expected 15 7", max_x, max_y);
        end
        checks++;
        if (sof_cnt !== 1 || sol_cnt !== 8) begin
            errors++; $display("FAIL nominal_pulses: got sof=%0d sol=%0d expected 1 8", sof_cnt, sol_cnt);
        end
        checks++;
        if (frame_errs !== 0) begin
            errors++; $display("FAIL nominal_frame3_stream: got %0d errors expected 0", frame_errs);
        end
    endtask

    task automatic test_alignment();
        set_geom(28, 16, 22, 3, 12, 8, 9, 2, 2, 1);
        run_frame(g_vtot);
        checks++;
        if (a5_hits !== 8) begin
            errors++; $display("FAIL align_a5_at_x0_sol: got %0d expected 8", a5_hits);
        end
        checks++;
        if (a5_total !== 8) begin
            errors++; $display("FAIL align_a5_total: got %0d expected 8", a5_total);
        end
        checks++;
        if (rgb_err !== 0 || pos_err !== 0) begin
            errors++; $display("FAIL align_stream: got rgb_err=%0d pos_err=%0d expected 0 0", rgb_err, pos_err);
        end
        checks++;
        if (lk_vs !== 1'b1) begin
            errors++; $display("FAIL align_locked: got %b expected 1", lk_vs);
        end
    endtask

    task automatic test_geometry_change();
        set_geom(28, 20, 22, 3, 12, 8, 9, 2, 1, 0);
        run_frame(g_vtot);
        checks++;
        if (lk_vs !== 1'b0) begin
            errors++; $display("FAIL geom_unlock: got %b expected 0", lk_vs);
        end
        checks++;
        if (h_active !== 10'd20) begin
            errors++; $display("FAIL geom_h_active_f1: got %0d expected 20", h_active);
        end
        run_frame(g_vtot);
        checks++;
        if (lk_vs !== 1'b0) begin
            errors++; $display("FAIL geom_relock_early: got %b expected 0", lk_vs);
        end
        run_frame(g_vtot);
        checks++;
        if (lk_vs !== 1'b1) begin
            errors++; $display("FAIL geom_relock: got %b expected 1", lk_vs);
        end
        checks++;
        if (h_active !== 10'd20 || h_total !== 10'd28) begin
            errors++; $display("FAIL geom_measure: got h_active=%0d h_total=%0d expected 20 28", h_active, h_total);
        end
        checks++;
        if (max_x !== 19 || frame_errs !== 0) begin
            errors++; $display("FAIL geom_stream: got max_x=%0d errs=%0d expected 19 0", max_x, frame_errs);
        end
    endtask

    task automatic test_watchdog();
        g_gap = 0;
        // Last hs fall was 5 samples before the end of the previous frame
        for (int i = 0; i < 1000; i++) pix(1'b1, 1'b1, 1'b1, 1'b1, 24'h0);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL wd_before_trip: got %b expected 1", locked);
        end
        for (int i = 0; i < 30; i++) pix(1'b1, 1'b1, 1'b1, 1'b1, 24'h0);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL wd_locked: got %b expected 0", locked);
        end
        checks++;
        if ({h_total, h_active, v_total, v_active} !== '0) begin
            errors++; $display("FAIL wd_measure: got %0d %0d %0d %0d expected 0 0 0 0",
                               h_total, h_active, v_total, v_active);
        end
    endtask

    task automatic test_simultaneous();
        set_geom(28, 20, 0, 3, 12, 8, 0, 2, 1, 0);
        run_frame(g_vtot);
        checks++;
        if (first_x !== 0 || first_y !== 0 || first_sof !== 1'b1) begin
            errors++; $display("FAIL simul_first_pixel: got x=%0d y=%0d sof=%b expected 0 0 1",
                               first_x, first_y, first_sof);
        end
        checks++;
        if (sof_cnt !== 1 || frame_errs !== 0) begin
            errors++; $display("FAIL simul_frame1: got sof=%0d errs=%0d expected 1 0", sof_cnt, frame_errs);
        end
        run_frame(g_vtot);
        run_frame(g_vtot);
        checks++;
        if (lk_vs !== 1'b1) begin
            errors++; $display("FAIL simul_locked: got %b expected 1", lk_vs);
        end
        checks++;
        if (h_total !== 10'd28 || v_total !== 9'd12) begin
            errors++; $display("FAIL simul_totals: got %0d %0d expected 28 12", h_total, v_total);
        end
        checks++;
        if (h_active !== 10'd20 || v_active !== 9'd8) begin
            errors++; $display("FAIL simul_actives: got %0d %0d expected 20 8", h_active, v_active);
        end
        checks++;
        if (sof_cnt !== 1 || frame_errs !== 0) begin
            errors++; $display("FAIL simul_frame3: got sof=%0d errs=%0d expected 1 0", sof_cnt, frame_errs);
        end
    endtask

    task automatic test_mid_reset();
        run_frame(5);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got %b expected 1", locked);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL midreset_async: outputs=%h expected 0", all_out);
        end
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_alignment();
        test_geometry_change();
        test_watchdog();
        test_simultaneous();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
